// File: rtl/sram_responder.sv
// Byte-lane SRAM slave model: 16-bit words, 8-bit data path, programmable read latency.
// Define SRAM_RESPONDER_INIT_CLEAR_EN to zero the whole array after every reset.
module sram_responder #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sram_chip_enablen,
  input  logic        sram_write_enablen,
  input  logic        sram_output_enablen,
  input  logic        sram_upper_byte,
  input  logic        sram_lower_byte,
  input  logic [15:0] address,
  input  logic [7:0]  sram_data_in,
  output logic [7:0]  sram_data_out,
  output logic        sram_data_oe,
  output logic        ready
);

  localparam int unsigned Depth   = 2 ** ADDR_WIDTH;
  localparam logic [2:0]  LatInit = 3'(READ_LATENCY);

`ifdef SRAM_RESPONDER_INIT_CLEAR_EN
  typedef enum logic [2:0] {StIdle, StReadWait, StReadValid, StWriteHold, StClear} state_e;
`else
  typedef enum logic [2:0] {StIdle, StReadWait, StReadValid, StWriteHold} state_e;
`endif

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            wdata_q;
  logic [1:0]            lanes_q;
  logic [2:0]            count_q;
  logic [7:0]            data_q;
  logic                  oe_q;
  logic                  ready_q;
`ifdef SRAM_RESPONDER_INIT_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_q;
`endif

  logic [15:0]           mem [Depth];

  logic                  ce;
  logic                  wr_req;
  logic                  rd_req;
  logic                  rd_held;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [1:0]            lanes_in;
  logic [15:0]           rd_word;
  logic [7:0]            rd_byte;

  assign ce       = ~sram_chip_enablen;
  assign wr_req   = ce & ~sram_write_enablen;
  assign rd_req   = ce & ~sram_output_enablen & sram_write_enablen;
  assign rd_held  = ce & ~sram_output_enablen;
  assign addr_in  = address[ADDR_WIDTH-1:0];
  // Bit 1 = upper lane, bit 0 = lower lane, active high.
  assign lanes_in = {~sram_upper_byte, ~sram_lower_byte};

  if (ADDR_WIDTH < 16) begin : g_unused_addr
    logic unused_addr;
    assign unused_addr = ^address[15:ADDR_WIDTH];
  end

  // In idle the read address is not latched yet; zero-latency reads need the live address.
  assign rd_word = mem[(state_q == StIdle) ? addr_in : addr_q];

  always_comb begin
    rd_byte = 8'h00;
    if (lanes_in[0]) begin
      rd_byte = rd_word[7:0];
    end else if (lanes_in[1]) begin
      rd_byte = rd_word[15:8];
    end
  end

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic [1:0]            mem_mask;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = {wdata_q, wdata_q};
    mem_mask  = lanes_q;
    if (!reset) begin
      if (state_q == StWriteHold && (sram_write_enablen || sram_chip_enablen)) begin
        mem_we = 1'b1;
      end
`ifdef SRAM_RESPONDER_INIT_CLEAR_EN
      if (state_q == StClear) begin
        mem_we    = 1'b1;
        mem_addr  = clr_q;
        mem_wdata = 16'h0000;
        mem_mask  = 2'b11;
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      if (mem_mask[0]) mem[mem_addr][7:0]  <= mem_wdata[7:0];
      if (mem_mask[1]) mem[mem_addr][15:8] <= mem_wdata[15:8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
`ifdef SRAM_RESPONDER_INIT_CLEAR_EN
      state_q <= StClear;
      clr_q   <= '0;
`else
      state_q <= StIdle;
`endif
      addr_q  <= '0;
      wdata_q <= 8'h00;
      lanes_q <= 2'b00;
      count_q <= 3'd0;
      data_q  <= 8'h00;
      oe_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      // Outputs default low; only a held valid read or a write commit raises them.
      data_q  <= 8'h00;
      oe_q    <= 1'b0;
      ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wr_req) begin
            addr_q  <= addr_in;
            wdata_q <= sram_data_in;
            lanes_q <= lanes_in;
            state_q <= StWriteHold;
          end else if (rd_req) begin
            addr_q  <= addr_in;
            count_q <= LatInit;
            if (READ_LATENCY == 0) begin
              state_q <= StReadValid;
              data_q  <= rd_byte;
              oe_q    <= 1'b1;
              ready_q <= 1'b1;
            end else begin
              state_q <= StReadWait;
            end
          end
        end
        StReadWait: begin
          if (!rd_held) begin
            state_q <= StIdle;
          end else if (count_q <= 3'd1) begin
            count_q <= 3'd0;
            state_q <= StReadValid;
            data_q  <= rd_byte;
            oe_q    <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            count_q <= count_q - 3'd1;
          end
        end
        StReadValid: begin
          if (!rd_held) begin
            state_q <= StIdle;
          end else if (addr_in != addr_q) begin
            addr_q  <= addr_in;
            count_q <= LatInit;
            state_q <= (READ_LATENCY == 0) ? StReadValid : StReadWait;
          end else begin
            data_q  <= rd_byte;
            oe_q    <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        StWriteHold: begin
          if (sram_write_enablen || sram_chip_enablen) begin
            ready_q <= 1'b1;
            state_q <= StIdle;
          end else begin
            wdata_q <= sram_data_in;
          end
        end
`ifdef SRAM_RESPONDER_INIT_CLEAR_EN
        StClear: begin
          clr_q <= clr_q + 1'b1;
          if (&clr_q) state_q <= StIdle;
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sram_data_out = data_q;
  assign sram_data_oe  = oe_q;
  assign ready         = ready_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed self-checking bench for sram_responder (ADDR_WIDTH=8, READ_LATENCY=2).
module tb_sram_responder;

  localparam int unsigned AW  = 8;
  localparam int unsigned LAT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        ce_n, we_n, oe_n, ub_n, lb_n;
  logic [15:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        doe;
  logic        rdy;

  int checks   = 0;
  int failures = 0;

  sram_responder #(
    .ADDR_WIDTH  (AW),
    .READ_LATENCY(LAT)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .sram_chip_enablen  (ce_n),
    .sram_write_enablen (we_n),
    .sram_output_enablen(oe_n),
    .sram_upper_byte    (ub_n),
    .sram_lower_byte    (lb_n),
    .address            (addr),
    .sram_data_in       (din),
    .sram_data_out      (dout),
    .sram_data_oe       (doe),
    .ready              (rdy)
  );

  always #5 clock = ~clock;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic bus_idle();
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic ub,
                          input logic lb, output logic rdy_hold, output logic rdy_pulse,
                          output logic rdy_after);
    @(negedge clock);
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; ub_n = ub; lb_n = lb; addr = a; din = d;
    @(negedge clock);
    rdy_hold = rdy;
    bus_idle();
    @(negedge clock);
    rdy_pulse = rdy;
    @(negedge clock);
    rdy_after = rdy;
  endtask

  task automatic do_read(input logic [15:0] a, input logic ub, input logic lb,
                         output logic early, output logic [7:0] data, output logic oe,
                         output logic r, output logic post_oe, output logic [7:0] post_data);
    @(negedge clock);
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; ub_n = ub; lb_n = lb; addr = a;
    early = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clock);
      early = early | doe | rdy;
    end
    @(negedge clock);
    data = dout; oe = doe; r = rdy;
    bus_idle();
    @(negedge clock);
    post_oe = doe | rdy; post_data = dout;
  endtask

  task automatic test_reset();
    bus_idle();
    addr = 16'h0000; din = 8'h00; reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", rdy); end
    checks++; if (doe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", doe); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
    reset = 1'b0;
`ifdef SRAM_RESPONDER_INIT_CLEAR_EN
    repeat (2 ** AW + 2) @(negedge clock);
`endif
  endtask

  task automatic test_basic();
    logic h, p, f, e, o, r, po;
    logic [7:0] d, pd;
    do_write(16'h0012, 8'hA5, 1'b0, 1'b0, h, p, f);
    checks++; if (h !== 1'b0) begin failures++; $display("FAIL wr_ready_hold got=%b exp=0", h); end
    checks++; if (p !== 1'b1) begin failures++; $display("FAIL wr_ready_pulse got=%b exp=1", p); end
    checks++; if (f !== 1'b0) begin failures++; $display("FAIL wr_ready_after got=%b exp=0", f); end
    do_read(16'h0012, 1'b1, 1'b0, e, d, o, r, po, pd);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL rd_early_valid got=%b exp=0", e); end
    checks++; if (d !== 8'hA5) begin failures++; $display("FAIL rd_data got=%h exp=a5", d); end
    checks++; if (o !== 1'b1 || r !== 1'b1) begin
      failures++; $display("FAIL rd_oe_ready got=%b%b exp=11", o, r);
    end
    checks++; if (po !== 1'b0 || pd !== 8'h00) begin
      failures++; $display("FAIL rd_release got=%b/%h exp=0/00", po, pd);
    end
  endtask

  task automatic test_lanes();
    logic h, p, f, e, o, r, po;
    logic [7:0] d, pd;
    do_write(16'h0040, 8'h11, 1'b0, 1'b1, h, p, f);
    do_write(16'h0040, 8'h22, 1'b1, 1'b0, h, p, f);
    do_write(16'h0040, 8'h3C, 1'b0, 1'b1, h, p, f);
    do_read(16'h0040, 1'b0, 1'b1, e, d, o, r, po, pd);
    checks++; if (d !== 8'h3C) begin failures++; $display("FAIL lane_upper got=%h exp=3c", d); end
    do_read(16'h0040, 1'b1, 1'b0, e, d, o, r, po, pd);
    checks++; if (d !== 8'h22) begin failures++; $display("FAIL lane_lower got=%h exp=22", d); end
    do_read(16'h0040, 1'b0, 1'b0, e, d, o, r, po, pd);
    checks++; if (d !== 8'h22) begin failures++; $display("FAIL lane_both got=%h exp=22", d); end
    do_read(16'h0040, 1'b1, 1'b1, e, d, o, r, po, pd);
    checks++; if (d !== 8'h00 || o !== 1'b1) begin
      failures++; $display("FAIL lane_none got=%h/%b exp=00/1", d, o);
    end
  endtask

  task automatic test_wrap();
    logic h, p, f, e, o, r, po;
    logic [7:0] d, pd;
    do_write(16'h0005, 8'h77, 1'b0, 1'b0, h, p, f);
    do_read(16'h0105, 1'b1, 1'b0, e, d, o, r, po, pd);
    checks++; if (d !== 8'h77) begin failures++; $display("FAIL wrap_read got=%h exp=77", d); end
    do_write(16'h0207, 8'h99, 1'b0, 1'b0, h, p, f);
    do_read(16'h0007, 1'b0, 1'b1, e, d, o, r, po, pd);
    checks++; if (d !== 8'h99) begin failures++; $display("FAIL wrap_write got=%h exp=99", d); end
  endtask

  task automatic test_abort();
    logic seen, e, o, r, po;
    logic [7:0] d, pd;
    @(negedge clock);
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; ub_n = 1'b1; lb_n = 1'b0; addr = 16'h0012;
    @(negedge clock);
    ce_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clock);
      seen = seen | doe | rdy;
    end
    bus_idle();
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_quiet got=%b exp=0", seen); end
    do_read(16'h0012, 1'b1, 1'b0, e, d, o, r, po, pd);
    checks++; if (d !== 8'hA5 || o !== 1'b1) begin
      failures++; $display("FAIL abort_reread got=%h/%b exp=a5/1", d, o);
    end
  endtask

  task automatic test_write_hold();
    logic h, p, f, e, o, r, po;
    logic [7:0] d, pd;
    @(negedge clock);
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
    addr = 16'h0050; din = 8'h10;
    @(negedge clock); din = 8'h20;
    @(negedge clock); din = 8'h30;
    @(negedge clock); bus_idle(); din = 8'h44;
    @(negedge clock);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL hold_ready got=%b exp=1", rdy); end
    do_read(16'h0050, 1'b1, 1'b0, e, d, o, r, po, pd);
    checks++; if (d !== 8'h30) begin failures++; $display("FAIL hold_relatch got=%h exp=30", d); end
    do_write(16'h0050, 8'hEE, 1'b1, 1'b1, h, p, f);
    checks++; if (p !== 1'b1) begin failures++; $display("FAIL nolane_ready got=%b exp=1", p); end
    do_read(16'h0050, 1'b0, 1'b1, e, d, o, r, po, pd);
    checks++; if (d !== 8'h30) begin failures++; $display("FAIL nolane_mem got=%h exp=30", d); end
  endtask

  task automatic test_addr_change();
    logic e;
    @(negedge clock);
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; ub_n = 1'b1; lb_n = 1'b0; addr = 16'h0012;
    repeat (LAT + 1) @(negedge clock);
    checks++; if (dout !== 8'hA5) begin failures++; $display("FAIL chg_first got=%h exp=a5", dout); end
    addr = 16'h0040;
    @(negedge clock);
    checks++; if (doe !== 1'b0 || rdy !== 1'b0) begin
      failures++; $display("FAIL chg_drop got=%b%b exp=00", doe, rdy);
    end
    e = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      @(negedge clock);
      e = e | doe;
    end
    @(negedge clock);
    checks++; if (e !== 1'b0 || doe !== 1'b1 || dout !== 8'h22) begin
      failures++; $display("FAIL chg_second got=%b/%b/%h exp=0/1/22", e, doe, dout);
    end
    bus_idle();
    @(negedge clock);
  endtask

  task automatic test_reset_mid_write();
    logic h, p, f, e, o, r, po, seen;
    logic [7:0] d, pd;
    do_write(16'h0060, 8'h00, 1'b0, 1'b0, h, p, f);
    @(negedge clock);
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0;
    addr = 16'h0060; din = 8'hFF;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    seen = rdy;
    bus_idle();
`ifdef SRAM_RESPONDER_INIT_CLEAR_EN
    repeat (2 ** AW) begin
      @(negedge clock);
      seen = seen | rdy;
    end
`else
    @(negedge clock);
    seen = seen | rdy;
`endif
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", seen); end
    do_read(16'h0060, 1'b1, 1'b0, e, d, o, r, po, pd);
    checks++; if (d !== 8'h00 || o !== 1'b1) begin
      failures++; $display("FAIL rst_discard got=%h/%b exp=00/1", d, o);
    end
`ifdef SRAM_RESPONDER_INIT_CLEAR_EN
    do_read(16'h0012, 1'b1, 1'b0, e, d, o, r, po, pd);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL clear_word got=%h exp=00", d); end
`else
    do_read(16'h0012, 1'b1, 1'b0, e, d, o, r, po, pd);
    checks++; if (d !== 8'hA5) begin failures++; $display("FAIL rst_retain got=%h exp=a5", d); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lanes();
    test_wrap();
    test_abort();
    test_write_hold();
    test_addr_change();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
- REQ-001: Parameter ADDR_WIDTH, default 8; word-address bits used; depth = 2^ADDR_WIDTH 16-bit words.
- REQ-002: Parameter READ_LATENCY, default 2; wait cycles before read data valid; legal range 0..7.
- REQ-003: clock  input  1  single clock; all state updates on rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: sram_chip_enablen  input  1  active-low chip enable.
- REQ-006: sram_write_enablen  input  1  active-low write strobe.
- REQ-007: sram_output_enablen  input  1  active-low output enable.
- REQ-008: sram_upper_byte  input  1  active-low upper lane select, bits 15:8.
- REQ-009: sram_lower_byte  input  1  active-low lower lane select, bits 7:0.
- REQ-010: address  input  16  word address; only bits ADDR_WIDTH-1:0 decoded.
- REQ-011: sram_data_in  input  8  write data from master.
- REQ-012: sram_data_out  output  8  read data.
- REQ-013: sram_data_oe  output  1  high while sram_data_out is valid and driven.
- REQ-014: ready  output  1  read data valid (level) or write committed (1-cycle pulse).

Function
- REQ-015: States: IDLE, READ_WAIT, READ_VALID, WRITE_HOLD; plus CLEAR when REQ-030 is active.
- REQ-016: IDLE, chip enabled, write strobe low: latch address, write data and lanes; go to WRITE_HOLD.
- REQ-017: IDLE, chip enabled, output enable low, write strobe high: latch address.
  - READ_LATENCY = 0: go to READ_VALID.
  - Otherwise: load the wait counter and go to READ_WAIT.
- REQ-018: Write and output-enable strobes both low in IDLE: treated as a write; write wins.
- REQ-019: WRITE_HOLD: sram_data_in re-latched every cycle; the last value before strobe release is stored.
- REQ-020: WRITE_HOLD exit on the first cycle that either the write strobe or chip enable is high.
  - Store latched data into each enabled lane only; disabled lanes unchanged.
  - ready = 1 for that one cycle; return to IDLE.
- REQ-021: WRITE_HOLD with both lanes disabled: the cycle completes and ready pulses, but memory is unchanged.
- REQ-022: READ_WAIT: counter decrements each cycle; go to READ_VALID when it reaches 0.
  - Chip enable or output enable deasserted: abort to IDLE; no sram_data_oe, no ready.
- REQ-023: READ_VALID: sram_data_oe = 1 and ready = 1, held level.
  - Lower lane enabled: output = lower byte, including when both lanes are enabled.
  - Only upper lane enabled: output = upper byte.
  - No lane enabled: output = 8'h00.
- REQ-024: READ_VALID, address change with strobes held: drop sram_data_oe and ready next cycle; restart at READ_WAIT (or READ_VALID if latency 0) using the new address.
- REQ-025: READ_VALID, chip enable or output enable high: return to IDLE; sram_data_oe and ready low next cycle.
- REQ-026: Address bits above ADDR_WIDTH are ignored, so aliasing wraps modulo depth.
- REQ-027: When sram_data_oe = 0, sram_data_out = 8'h00.

Reset
- REQ-028: Reset high: state to IDLE (or CLEAR per REQ-030); counter, latches, sram_data_out, sram_data_oe and ready all go to 0 on the next edge.
- REQ-029: Reset mid-write discards the pending write; reset mid-read drops output the following cycle.
  - Without REQ-030, memory contents are retained across reset.

Configuration
- REQ-030: Macro SRAM_RESPONDER_INIT_CLEAR_EN.
  - Defined: reset enters CLEAR, which writes 16'h0000 to one word per cycle from address 0 upward.
  - CLEAR lasts 2^ADDR_WIDTH cycles, then goes to IDLE.
  - During CLEAR, strobes are ignored and ready = 0; reset re-asserted during CLEAR restarts at word 0.
  - Undefined: no CLEAR state; contents are undefined after power-up and retained across reset.

Verification
- REQ-031: Write 8'hA5 to address 16'h0012, both lanes enabled, then read with lower lane.
  - Required: ready pulses once on the write; on the read, sram_data_out = 8'hA5 exactly READ_LATENCY+1 cycles after strobe.
- REQ-032: Write 8'h3C with only the upper lane to an address holding 16'h1122, then read with each lane.
  - Required: upper read = 8'h3C, lower read = 8'h22.
- REQ-033: Read of address 16'h0105 with ADDR_WIDTH = 8 returns the word stored at 16'h0005 (wrap).
- REQ-034: Chip enable released during READ_WAIT: sram_data_oe and ready stay 0; a new read afterward completes normally.
- REQ-035: Reset pulsed during WRITE_HOLD of 8'hFF to an address holding 8'h00: read afterward returns 8'h00.
  - With SRAM_RESPONDER_INIT_CLEAR_EN defined: ready stays 0 for 256 cycles after reset and all words read 8'h00.
